ahb_protocol_checker: RTL and testbench
=======================================

Name: ahb_protocol_checker

Overview:
- Synthesizable, parametrised AHB-Lite protocol checker; connects passively to the memory-slave bus (AHBInterface signals) alongside the slave under test.
- Tracks address/data pipeline and burst progress with an FSM; evaluates 8 numbered checks; keeps per-check saturating pass/fail counters and sticky fail flags.
- Generalises the simulation-only assertion monitor: NUM_SLAVES, region size, read-only window and data/address widths are parameters; burst address/wrap tracking is added.

Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA width
- NUM_SLAVES, 2, slave regions mapped from address 0
- REGION_AW, 10, log2 bytes per slave region (legal map = NUM_SLAVES * 2**REGION_AW bytes)
- RO_BYTES, 4, bytes at the start of each region that are read-only
- CNT_W, 16, pass/fail counter width

Ports:
- HCLK  in  1  clock
- reset  in  1  asynchronous, active-high reset
- HADDR  in  ADDR_W  bus address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  write flag
- HSIZE  in  3  transfer size, log2 bytes
- HBURST  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
- HWDATA  in  DATA_W  write data
- HREADY  in  1  transfer done / wait
- HRESP  in  1  0=OKAY, 1=ERROR
- clr  in  1  synchronous clear of counters, flags and log
- chk_sel  in  3  check index for counter readout
- pass_cnt  out  CNT_W  registered pass count of chk_sel
- fail_cnt  out  CNT_W  registered fail count of chk_sel
- fail_sticky  out  8  bit n set on any fail of check n
- fail_pulse  out  1  high one cycle after any check fails
- burst_active  out  1  FSM in BURST
- beats_left  out  5  remaining beats of active fixed burst
- first_fail_addr  out  ADDR_W  see Optional Feature
- first_fail_id  out  3  see Optional Feature
- first_fail_vld  out  1  see Optional Feature

Behaviour:
- Reset: all counters, fail_sticky, fail_pulse, burst_active, beats_left, pass_cnt, fail_cnt, first_fail_* = 0; FSM = IDLE; data-phase registers invalid.
- Address phase accepted when HREADY=1: HADDR/HTRANS/HWRITE/HSIZE/HBURST registered into data-phase regs (dp_*). Data phase completes on the next cycle with HREADY=1.
- Checks are evaluated at data-phase completion unless noted. Each evaluation increments exactly one counter, pass or fail:
  - 0 ADDR_RANGE: dp NONSEQ/SEQ with dp_addr >= NUM_SLAVES<<REGION_AW -> pass iff HRESP=1.
  - 1 READ_ONLY: dp write, in range, (dp_addr mod 2**REGION_AW) < RO_BYTES -> pass iff HRESP=1.
  - 2 IDLE_OKAY: dp IDLE/BUSY -> pass iff HREADY=1 and HRESP=0 in the first data-phase cycle.
  - 3 WAIT_STABLE: every cycle following a cycle with HREADY=0 -> pass iff HADDR, HTRANS, HWRITE, HSIZE, HBURST and HWDATA equal previous-cycle values. Exception: HTRANS IDLE->NONSEQ change is legal.
  - 4 BURST_SEQ: accepted NONSEQ or IDLE while beats_left>0 -> fail; last beat accepted -> pass.
  - 5 BURST_ADDR: accepted SEQ in BURST -> pass iff HADDR == expected address.
  - 6 BURST_CTRL: accepted SEQ/BUSY in BURST -> pass iff HWRITE, HSIZE, HBURST equal burst-start values.
  - 7 SEQ_START: accepted SEQ while FSM IDLE and previous accepted transfer not INCR -> fail; otherwise no evaluation.
- Burst FSM: IDLE -> BURST on accepted NONSEQ with HBURST in {2..7}; beats_left = 4/8/16 minus 1. Each accepted SEQ decrements beats_left; BUSY holds it. BURST -> IDLE when beats_left reaches 0, on accepted NONSEQ/IDLE (check 4 fail; a NONSEQ then restarts the FSM in the same cycle), or when HRESP=1 completes a beat (abort, no fail).
- Expected address: incr = 1<<HSIZE; INCRx: prev+incr; WRAPx: boundary = beats*incr, next = (prev & ~(boundary-1)) | ((prev+incr) & (boundary-1)).
- Counters saturate at 2**CNT_W-1. clr wins over a simultaneous event. fail_pulse/fail_sticky update one cycle after evaluation. pass_cnt/fail_cnt are registered, 1-cycle latency from chk_sel.
- Reset mid-burst: FSM to IDLE; no evaluation of the pending beat.

Optional Feature:
- AHB_CHK_FAIL_LOG_EN defined: on the first fail after reset/clr, capture HADDR of the failing transfer in first_fail_addr and the check index in first_fail_id; set first_fail_vld. Lowest index wins on simultaneous fails; later fails ignored until clr.
- Undefined: first_fail_* tied to 0; no log registers.

Test Plan:
- Read NONSEQ at 0x900, slave HRESP=1 -> check 0 pass_cnt=1; HRESP=0 instead -> fail_cnt=1, fail_sticky[0]=1, fail_pulse one cycle.
- Write SINGLE to 0x402 (RO window of slave 1), HRESP=1 -> check 1 pass=1; write to 0x404 -> no check-1 evaluation.
- WRAP4 word burst from 0x38 -> expected 0x3C, 0x30, 0x34; drive correctly -> check 5 pass=3, check 4 pass=1, burst_active low after beat 4.
- INCR8 aborted by NONSEQ after 3 beats -> check 4 fail=1; new burst started, beats_left=7.
- HREADY=0 for 2 cycles, HADDR changed in the second -> check 3 fail=1; with AHB_CHK_FAIL_LOG_EN, first_fail_id=3, first_fail_vld=1.
- Force 2**CNT_W+5 IDLE transfers, then clr with simultaneous IDLE -> counter saturates at max, then reads 0.

Source files
------------

// File: rtl/ahb_protocol_checker.sv
// ahb_protocol_checker: passive AHB-Lite checker with burst tracking, per-check counters; AHB_CHK_FAIL_LOG_EN adds first-fail log
module ahb_protocol_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 2,
  parameter int REGION_AW  = 10,
  parameter int RO_BYTES   = 4,
  parameter int CNT_W      = 16
) (
  input  logic              HCLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic              clr,
  input  logic [2:0]        chk_sel,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [7:0]        fail_sticky,
  output logic              fail_pulse,
  output logic              burst_active,
  output logic [4:0]        beats_left,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [2:0]        first_fail_id,
  output logic              first_fail_vld
);
  localparam logic [ADDR_W-1:0]    LIMIT = ADDR_W'(NUM_SLAVES) << REGION_AW;
  localparam logic [REGION_AW-1:0] RO    = REGION_AW'(RO_BYTES);
  localparam logic [CNT_W-1:0]     MAX   = '1;
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t state_q, state_d;
  logic              dp_vld_q, dp_vld_d, dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic [1:0]        dp_trans_q, dp_trans_d;
  logic [2:0]        dp_size_q, dp_size_d, dp_burst_q, dp_burst_d;
  logic              hready_q, hready_d, p_write_q, p_write_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [1:0]        p_trans_q, p_trans_d;
  logic [2:0]        p_size_q, p_size_d, p_burst_q, p_burst_d;
  logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
  logic [4:0]        beats_q, beats_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic              b_write_q, b_write_d;
  logic [2:0]        b_size_q, b_size_d, b_burst_q, b_burst_d;
  logic [CNT_W-1:0]  pass_q [8], pass_d [8], fail_q [8], fail_d [8];
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [7:0]        sticky_q, sticky_d, ev, ok, fv;
  logic              pulse_q, pulse_d, done, abort, in_b;

  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a, input logic [2:0] sz, input logic [2:0] bt);
    logic [ADDR_W-1:0] inc, m;
    inc = ADDR_W'(1) << sz;
    m = ((ADDR_W'(4) << (bt[2:1] - 2'd1)) << sz) - ADDR_W'(1);
    return bt[0] ? a + inc : (a & ~m) | ((a + inc) & m);
  endfunction

  // pipeline tracking, burst FSM, check evaluation and counter next-state
  always_comb begin
    state_d    = state_q;
    dp_vld_d   = dp_vld_q;
    dp_addr_d  = dp_addr_q;
    dp_trans_d = dp_trans_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_burst_d = dp_burst_q;
    beats_d    = beats_q;
    exp_d      = exp_q;
    b_write_d  = b_write_q;
    b_size_d   = b_size_q;
    b_burst_d  = b_burst_q;
    hready_d   = HREADY;
    p_addr_d   = HADDR;
    p_trans_d  = HTRANS;
    p_write_d  = HWRITE;
    p_size_d   = HSIZE;
    p_burst_d  = HBURST;
    p_wdata_d  = HWDATA;
    ev = '0;
    ok = '0;
    done  = dp_vld_q & HREADY;
    abort = (state_q == S_BURST) & done & HRESP;
    in_b  = (state_q == S_BURST) & ~abort;
    ev[0] = done & dp_trans_q[1] & (dp_addr_q >= LIMIT);
    ok[0] = HRESP;
    ev[1] = done & dp_trans_q[1] & dp_write_q & (dp_addr_q < LIMIT) & (dp_addr_q[REGION_AW-1:0] < RO);
    ok[1] = HRESP;
    ev[2] = dp_vld_q & hready_q & ~dp_trans_q[1];
    ok[2] = HREADY & ~HRESP;
    ev[3] = ~hready_q;
    ok[3] = (HADDR == p_addr_q) & (HWRITE == p_write_q) & (HSIZE == p_size_q) & (HBURST == p_burst_q) &
            (HWDATA == p_wdata_q) & ((HTRANS == p_trans_q) | ((p_trans_q == 2'd0) & (HTRANS == 2'd2)));
    if (abort) begin
      state_d = S_IDLE;
      beats_d = '0;
    end
    if (HREADY) begin
      dp_vld_d   = 1'b1;
      dp_addr_d  = HADDR;
      dp_trans_d = HTRANS;
      dp_write_d = HWRITE;
      dp_size_d  = HSIZE;
      dp_burst_d = HBURST;
      if (in_b) begin
        if (HTRANS == 2'd3) begin
          ev[5] = 1'b1;
          ok[5] = HADDR == exp_q;
          ev[6] = 1'b1;
          ok[6] = (HWRITE == b_write_q) & (HSIZE == b_size_q) & (HBURST == b_burst_q);
          beats_d = beats_q - 5'd1;
          exp_d = nxt(exp_q, b_size_q, b_burst_q);
          ev[4] = beats_q == 5'd1;
          ok[4] = 1'b1;
          state_d = beats_q == 5'd1 ? S_IDLE : S_BURST;
        end else if (HTRANS == 2'd1) begin
          ev[6] = 1'b1;
          ok[6] = (HWRITE == b_write_q) & (HSIZE == b_size_q) & (HBURST == b_burst_q);
        end else begin
          ev[4] = 1'b1;
          state_d = S_IDLE;
          beats_d = '0;
        end
      end else begin
        ev[7] = (HTRANS == 2'd3) & ~(dp_vld_q & (dp_trans_q != 2'd0) & (dp_burst_q == 3'd1));
      end
      if (HTRANS == 2'd2 && HBURST[2:1] != 2'd0) begin
        state_d   = S_BURST;
        beats_d   = (5'd4 << (HBURST[2:1] - 2'd1)) - 5'd1;
        exp_d     = nxt(HADDR, HSIZE, HBURST);
        b_write_d = HWRITE;
        b_size_d  = HSIZE;
        b_burst_d = HBURST;
      end
    end
    fv = ev & ~ok;
    for (int i = 0; i < 8; i++) begin
      pass_d[i] = clr ? '0 : pass_q[i] + CNT_W'(ev[i] & ok[i] & (pass_q[i] != MAX));
      fail_d[i] = clr ? '0 : fail_q[i] + CNT_W'(fv[i] & (fail_q[i] != MAX));
    end
    sticky_d   = clr ? '0 : sticky_q | fv;
    pulse_d    = ~clr & (|fv);
    pass_cnt_d = pass_q[chk_sel];
    fail_cnt_d = fail_q[chk_sel];
  end

  // state registers
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dp_vld_q   <= 1'b0;
      dp_addr_q  <= '0;
      dp_trans_q <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= '0;
      dp_burst_q <= '0;
      hready_q   <= 1'b1;
      p_addr_q   <= '0;
      p_trans_q  <= '0;
      p_write_q  <= 1'b0;
      p_size_q   <= '0;
      p_burst_q  <= '0;
      p_wdata_q  <= '0;
      beats_q    <= '0;
      exp_q      <= '0;
      b_write_q  <= 1'b0;
      b_size_q   <= '0;
      b_burst_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        pass_q[i] <= '0;
        fail_q[i] <= '0;
      end
      sticky_q   <= '0;
      pulse_q    <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dp_vld_q   <= dp_vld_d;
      dp_addr_q  <= dp_addr_d;
      dp_trans_q <= dp_trans_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      dp_burst_q <= dp_burst_d;
      hready_q   <= hready_d;
      p_addr_q   <= p_addr_d;
      p_trans_q  <= p_trans_d;
      p_write_q  <= p_write_d;
      p_size_q   <= p_size_d;
      p_burst_q  <= p_burst_d;
      p_wdata_q  <= p_wdata_d;
      beats_q    <= beats_d;
      exp_q      <= exp_d;
      b_write_q  <= b_write_d;
      b_size_q   <= b_size_d;
      b_burst_q  <= b_burst_d;
      for (int i = 0; i < 8; i++) begin
        pass_q[i] <= pass_d[i];
        fail_q[i] <= fail_d[i];
      end
      sticky_q   <= sticky_d;
      pulse_q    <= pulse_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign fail_sticky  = sticky_q;
  assign fail_pulse   = pulse_q;
  assign burst_active = state_q == S_BURST;
  assign beats_left   = beats_q;

`ifdef AHB_CHK_FAIL_LOG_EN
  logic [ADDR_W-1:0] log_addr_q, log_addr_d;
  logic [2:0]        log_id_q, log_id_d, fid;
  logic              log_vld_q, log_vld_d;

  // capture the first failing check (lowest index on ties) until cleared
  always_comb begin
    fid = '0;
    for (int i = 7; i >= 0; i--) if (fv[i]) fid = 3'(i);
    log_addr_d = clr ? '0 : log_addr_q;
    log_id_d   = clr ? '0 : log_id_q;
    log_vld_d  = clr ? 1'b0 : log_vld_q;
    if (!clr && !log_vld_q && |fv) begin
      log_vld_d  = 1'b1;
      log_id_d   = fid;
      log_addr_d = fid < 3'd3 ? dp_addr_q : HADDR;
    end
  end

  // log registers
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      log_addr_q <= '0;
      log_id_q   <= '0;
      log_vld_q  <= 1'b0;
    end else begin
      log_addr_q <= log_addr_d;
      log_id_q   <= log_id_d;
      log_vld_q  <= log_vld_d;
    end
  end

  assign first_fail_addr = log_addr_q;
  assign first_fail_id   = log_id_q;
  assign first_fail_vld  = log_vld_q;
`else
  assign first_fail_addr = '0;
  assign first_fail_id   = '0;
  assign first_fail_vld  = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_protocol_checker.sv
// tb_ahb_protocol_checker: directed self-checking bench for ahb_protocol_checker
module tb_ahb_protocol_checker;
  logic        HCLK, reset, HWRITE, HREADY, HRESP, clr, fail_pulse, burst_active, first_fail_vld;
  logic [31:0] HADDR, HWDATA, first_fail_addr;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST, chk_sel, first_fail_id;
  logic [3:0]  pass_cnt, fail_cnt;
  logic [7:0]  fail_sticky;
  logic [4:0]  beats_left;
  int tests = 0, fails = 0;

  ahb_protocol_checker #(.CNT_W(4)) dut (
    .HCLK(HCLK), .reset(reset), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .clr(clr), .chk_sel(chk_sel),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_sticky(fail_sticky), .fail_pulse(fail_pulse),
    .burst_active(burst_active), .beats_left(beats_left), .first_fail_addr(first_fail_addr),
    .first_fail_id(first_fail_id), .first_fail_vld(first_fail_vld)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] s,
                     input logic [2:0] b, input logic rdy, input logic rsp);
    HADDR = a; HTRANS = t; HWRITE = w; HSIZE = s; HBURST = b; HREADY = rdy; HRESP = rsp;
    tick();
  endtask

  task automatic idle;
    bus(32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic clear;
    clr = 1'b1;
    idle();
    clr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] n, input int p, input int f, input string tag);
    chk_sel = n;
    idle();
    idle();
    chk({tag, "_pass"}, 32'(pass_cnt), p);
    chk({tag, "_fail"}, 32'(fail_cnt), f);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; chk_sel = 3'd0; HWDATA = 32'h0;
    HADDR = 32'h0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) tick();
    chk("rst_pass_cnt", 32'(pass_cnt), 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);
    chk("rst_sticky", 32'(fail_sticky), 0);
    chk("rst_pulse", 32'(fail_pulse), 0);
    chk("rst_burst", 32'(burst_active), 0);
    chk("rst_beats", 32'(beats_left), 0);
    chk("rst_log_vld", 32'(first_fail_vld), 0);
    reset = 1'b0;
    idle();
    clear();
    // out-of-range read answered with ERROR
    bus(32'h900, 2'd2, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    bus(32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
    idle();
    rd(3'd0, 1, 0, "c0_err");
    chk("c0_err_sticky", 32'(fail_sticky), 0);
    clear();
    // out-of-range read answered OKAY
    bus(32'h900, 2'd2, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    bus(32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk("c0_ok_pulse_hi", 32'(fail_pulse), 1);
    chk("c0_ok_sticky", 32'(fail_sticky), 32'h01);
    idle();
    chk("c0_ok_pulse_lo", 32'(fail_pulse), 0);
    rd(3'd0, 0, 1, "c0_ok");
    clear();
    chk("clr_sticky", 32'(fail_sticky), 0);
    // write into read-only window, then just past it
    bus(32'h402, 2'd2, 1'b1, 3'd1, 3'd0, 1'b1, 1'b0);
    bus(32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
    idle();
    rd(3'd1, 1, 0, "c1_ro");
    bus(32'h404, 2'd2, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0);
    idle();
    idle();
    rd(3'd1, 1, 0, "c1_rw");
    rd(3'd0, 0, 0, "c0_inrange");
    clear();
    // WRAP4 word burst from 0x38
    bus(32'h38, 2'd2, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0);
    chk("w4_active", 32'(burst_active), 1);
    chk("w4_beats", 32'(beats_left), 3);
    bus(32'h3C, 2'd3, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0);
    bus(32'h30, 2'd3, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0);
    chk("w4_active3", 32'(burst_active), 1);
    bus(32'h34, 2'd3, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0);
    chk("w4_done", 32'(burst_active), 0);
    idle();
    rd(3'd5, 3, 0, "w4_c5");
    rd(3'd4, 1, 0, "w4_c4");
    rd(3'd6, 3, 0, "w4_c6");
    rd(3'd7, 0, 0, "w4_c7");
    clear();
    // INCR8 cut short by a new NONSEQ INCR8
    bus(32'h100, 2'd2, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    bus(32'h104, 2'd3, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    bus(32'h108, 2'd3, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("i8_beats5", 32'(beats_left), 5);
    bus(32'h200, 2'd2, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("i8_restart_active", 32'(burst_active), 1);
    chk("i8_restart_beats", 32'(beats_left), 7);
    chk("i8_c4_sticky", 32'(fail_sticky), 32'h10);
    for (int i = 1; i <= 7; i++) bus(32'h200 + 32'(4 * i), 2'd3, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("i8_end", 32'(burst_active), 0);
    rd(3'd4, 1, 1, "i8_c4");
    rd(3'd5, 9, 0, "i8_c5");
    clear();
    // wait state with address changed in second wait cycle
    bus(32'h10, 2'd2, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    bus(32'h20, 2'd2, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    bus(32'h24, 2'd2, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
    bus(32'h24, 2'd2, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    idle();
    rd(3'd3, 1, 1, "ws_c3");
    chk("ws_sticky", 32'(fail_sticky), 32'h08);
`ifdef AHB_CHK_FAIL_LOG_EN
    chk("log_vld", 32'(first_fail_vld), 1);
    chk("log_id", 32'(first_fail_id), 3);
    chk("log_addr", first_fail_addr, 32'h24);
`else
    chk("log_vld_off", 32'(first_fail_vld), 0);
    chk("log_id_off", 32'(first_fail_id), 0);
    chk("log_addr_off", first_fail_addr, 0);
`endif
    clear();
    // SEQ legal after INCR, illegal after IDLE
    bus(32'h40, 2'd2, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0);
    bus(32'h44, 2'd3, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0);
    idle();
    rd(3'd7, 0, 0, "c7_incr");
    bus(32'h48, 2'd3, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    idle();
    rd(3'd7, 0, 1, "c7_idle");
    chk("c7_sticky", 32'(fail_sticky), 32'h80);
    clear();
    // IDLE saturation then clear with concurrent IDLE
    chk_sel = 3'd2;
    repeat (21) idle();
    chk("sat_pass", 32'(pass_cnt), 15);
    chk("sat_fail", 32'(fail_cnt), 0);
    clear();
    idle();
    chk("sat_clr", 32'(pass_cnt), 0);
    // reset in the middle of a burst
    bus(32'h80, 2'd2, 1'b0, 3'd2, 3'd4, 1'b1, 1'b0);
    chk("mid_active", 32'(burst_active), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_active", 32'(burst_active), 0);
    chk("mid_rst_beats", 32'(beats_left), 0);
    reset = 1'b0;
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
